// File: rtl/prince_sched_pkg.sv
// rtl/prince_sched_pkg.sv - shared states, constants and types for the PRINCE S-box scheduler
package prince_sched_pkg;

    localparam int SB_LAT = 6;
    localparam int NIB    = 16;
    localparam int RW     = 38;

    typedef logic [3:0] nib_idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE,
        ST_ABORT
    } state_t;

endpackage

// File: rtl/prince_sbox_tagpipe.sv
// rtl/prince_sbox_tagpipe.sv - {valid, tag} shift register shadowing the S-box pipeline
module prince_sbox_tagpipe #(
    parameter int DEPTH = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push_valid,
    input  logic [3:0] push_tag,
    output logic       tail_valid,
    output logic [3:0] tail_tag,
    output logic       occupied,
    output logic       pending
);

    logic [DEPTH-1:0] valid_q;
    logic [3:0]       tag_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i] <= 4'd0;
            end
        end else begin
            valid_q  <= {valid_q[DEPTH-2:0], push_valid};
            tag_q[0] <= push_tag;
            for (int i = 1; i < DEPTH; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    assign tail_valid = valid_q[DEPTH-1];
    assign tail_tag   = tag_q[DEPTH-1];
    assign occupied   = |valid_q;
    // Entries behind the tail; when clear and nothing is pushed, the pipe is empty after this edge.
    assign pending    = |valid_q[DEPTH-2:0];

endmodule

// File: rtl/prince_sbox_sched.sv
// rtl/prince_sbox_sched.sv - nibble-serial issue/capture scheduler for one shared masked inverse S-box
module prince_sbox_sched #(
    parameter int SB_LAT = prince_sched_pkg::SB_LAT,
    parameter int NIB    = prince_sched_pkg::NIB,
    parameter int RW     = prince_sched_pkg::RW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [63:0]   in_s1,
    input  logic [63:0]   in_s2,
    input  logic [63:0]   in_s3,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [63:0]   out_s1,
    output logic [63:0]   out_s2,
    output logic [63:0]   out_s3,
    input  logic [RW-1:0] rnd,
    input  logic          rnd_valid,
    output logic          rnd_ready,
    output logic [3:0]    sb_in1,
    output logic [3:0]    sb_in2,
    output logic [3:0]    sb_in3,
    output logic [RW-1:0] sb_r,
    input  logic [3:0]    sb_out1,
    input  logic [3:0]    sb_out2,
    input  logic [3:0]    sb_out3
);

    import prince_sched_pkg::*;

    state_t      state_q, state_d;
    logic [63:0] sh1_q, sh2_q, sh3_q;
    logic [63:0] out1_q, out2_q, out3_q;
    nib_idx_t    k_q;
    logic        err_q;

    logic        issue;
    logic        starve;
    logic        tail_valid;
    logic [3:0]  tail_tag;
    logic        occupied;
    logic        pending;

    prince_sbox_tagpipe #(
        .DEPTH(SB_LAT)
    ) u_tagpipe (
        .clk        (clk),
        .rst        (rst),
        .push_valid (issue),
        .push_tag   (k_q),
        .tail_valid (tail_valid),
        .tail_tag   (tail_tag),
        .occupied   (occupied),
        .pending    (pending)
    );

    assign issue  = (state_q == ST_RUN) && rnd_valid;
    assign starve = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !rnd_valid && occupied;

    // DRAIN and ABORT leave as the last entry is captured, so DONE sees an empty pipe.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start) state_d = ST_RUN;
            ST_RUN: begin
                if (starve)                               state_d = ST_ABORT;
                else if (issue && (k_q == 4'(NIB - 1)))   state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (starve)        state_d = ST_ABORT;
                else if (!pending) state_d = ST_DONE;
            end
            ST_DONE:  state_d = ST_IDLE;
            ST_ABORT: if (!pending) state_d = ST_DONE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            k_q     <= 4'd0;
            err_q   <= 1'b0;
            sh1_q   <= '0;
            sh2_q   <= '0;
            sh3_q   <= '0;
            out1_q  <= '0;
            out2_q  <= '0;
            out3_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        sh1_q  <= in_s1;
                        sh2_q  <= in_s2;
                        sh3_q  <= in_s3;
                        out1_q <= '0;
                        out2_q <= '0;
                        out3_q <= '0;
                        err_q  <= 1'b0;
                        k_q    <= 4'd0;
                    end
                end
                ST_RUN: if (issue) k_q <= k_q + 4'd1;
                ST_ABORT: begin
                    out1_q <= '0;
                    out2_q <= '0;
                    out3_q <= '0;
                    if (!pending) err_q <= 1'b1;
                end
                default: ;
            endcase
            if (tail_valid && (state_q != ST_ABORT)) begin
                out1_q[{tail_tag, 2'b00} +: 4] <= sb_out1;
                out2_q[{tail_tag, 2'b00} +: 4] <= sb_out2;
                out3_q[{tail_tag, 2'b00} +: 4] <= sb_out3;
            end
        end
    end

    assign busy      = (state_q == ST_RUN) || (state_q == ST_DRAIN) || (state_q == ST_ABORT);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign out_s1    = out1_q;
    assign out_s2    = out2_q;
    assign out_s3    = out3_q;
    assign rnd_ready = busy && rnd_valid && (issue || occupied);
    assign sb_r      = rnd_ready ? rnd : '0;
    assign sb_in1    = issue ? sh1_q[{k_q, 2'b00} +: 4] : 4'd0;
    assign sb_in2    = issue ? sh2_q[{k_q, 2'b00} +: 4] : 4'd0;
    assign sb_in3    = issue ? sh3_q[{k_q, 2'b00} +: 4] : 4'd0;

endmodule

// File: tb/tb_prince_sbox_sched.sv
// tb/tb_prince_sbox_sched.sv - randomized self-checking bench with a golden masked S-box beside the DUT
module tb_prince_sbox_sched;

    localparam int RW     = 38;
    localparam int SB_LAT = 6;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [63:0]   in_s1, in_s2, in_s3;
    logic          busy, done, err;
    logic [63:0]   out_s1, out_s2, out_s3;
    logic [RW-1:0] rnd;
    logic          rnd_valid, rnd_ready;
    logic [3:0]    sb_in1, sb_in2, sb_in3;
    logic [RW-1:0] sb_r;
    logic [3:0]    sb_out1, sb_out2, sb_out3;

    int errors = 0;
    int checks = 0;

    prince_sbox_sched dut (
        .clk(clk), .rst(rst), .start(start),
        .in_s1(in_s1), .in_s2(in_s2), .in_s3(in_s3),
        .busy(busy), .done(done), .err(err),
        .out_s1(out_s1), .out_s2(out_s2), .out_s3(out_s3),
        .rnd(rnd), .rnd_valid(rnd_valid), .rnd_ready(rnd_ready),
        .sb_in1(sb_in1), .sb_in2(sb_in2), .sb_in3(sb_in3), .sb_r(sb_r),
        .sb_out1(sb_out1), .sb_out2(sb_out2), .sb_out3(sb_out3)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'hB;  4'h1: return 4'h7;  4'h2: return 4'h3;  4'h3: return 4'h2;
            4'h4: return 4'hF;  4'h5: return 4'hD;  4'h6: return 4'h8;  4'h7: return 4'h9;
            4'h8: return 4'hA;  4'h9: return 4'h6;  4'hA: return 4'h4;  4'hB: return 4'h0;
            4'hC: return 4'h5;  4'hD: return 4'hE;  4'hE: return 4'hC;  default: return 4'h1;
        endcase
    endfunction

    function automatic logic [63:0] inv_layer(input logic [63:0] x);
        logic [63:0] r;
        for (int i = 0; i < 16; i++) r[i*4 +: 4] = inv_sbox(x[i*4 +: 4]);
        return r;
    endfunction

    function automatic logic [RW-1:0] rand_word();
        logic [63:0] w;
        w = {$urandom, $urandom};
        return w[RW-1:0];
    endfunction

    // Golden 3-share S-box: fresh masks taken from r, SB_LAT register stages.
    logic [11:0] sb_pipe [SB_LAT];
    initial for (int i = 0; i < SB_LAT; i++) sb_pipe[i] = 12'd0;
    always @(posedge clk) begin
        for (int i = SB_LAT - 1; i > 0; i--) sb_pipe[i] <= sb_pipe[i-1];
        sb_pipe[0] <= {sb_r[7:4], sb_r[3:0],
                       inv_sbox(sb_in1 ^ sb_in2 ^ sb_in3) ^ sb_r[3:0] ^ sb_r[7:4]};
    end
    assign {sb_out3, sb_out2, sb_out1} = sb_pipe[SB_LAT-1];

    task automatic run_op(input logic [63:0] a1, a2, a3,
                          input int drop_lo, drop_hi, rst_at, busy_start_at,
                          output int done_rel, output logic err_o, output logic [63:0] xr,
                          output int n_ready, output int first_ready, output int bad_r,
                          output logic busy1, output logic err1);
        logic [RW-1:0] seen[$];
        done_rel = -1; first_ready = -1; n_ready = 0; bad_r = 0;
        err_o = 1'b0; xr = '0; busy1 = 1'b0; err1 = 1'b0;
        @(negedge clk);
        start = 1'b1; in_s1 = a1; in_s2 = a2; in_s3 = a3;
        rnd_valid = 1'b1; rnd = rand_word(); rst = 1'b0;
        #1;
        for (int rel = 1; rel <= 150; rel++) begin
            @(negedge clk);
            start = (rel == busy_start_at);
            in_s1 = {$urandom, $urandom}; in_s2 = {$urandom, $urandom}; in_s3 = {$urandom, $urandom};
            rnd_valid = !((rel >= drop_lo) && (rel <= drop_hi));
            rnd = rand_word();
            rst = (rel == rst_at);
            #1;
            if (rel == 1) begin
                busy1 = busy;
                err1  = err;
            end
            if (rnd_ready) begin
                n_ready++;
                if (first_ready < 0) first_ready = rel;
                if (sb_r !== rnd) bad_r++;
                foreach (seen[i]) if (seen[i] == sb_r) bad_r++;
                seen.push_back(sb_r);
            end else if (sb_r !== '0) begin
                bad_r++;
            end
            if (done) begin
                done_rel = rel;
                err_o    = err;
                xr       = out_s1 ^ out_s2 ^ out_s3;
                break;
            end
            if ((rst_at >= 0) && (rel == rst_at + 1)) break;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    int          d_rel, n_rdy, f_rdy, bad;
    logic        e_o, b1, e1;
    logic [63:0] xr, a1, a2, a3, x;

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b1; rnd = rand_word();
        in_s1 = '1; in_s2 = '1; in_s3 = '1;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({busy, done, err, rnd_ready} !== 4'b0) begin errors++;
            $display("FAIL reset_flags: got %b want 0000", {busy, done, err, rnd_ready}); end
        checks++; if ({sb_in1, sb_in2, sb_in3} !== 12'd0 || sb_r !== '0) begin errors++;
            $display("FAIL reset_sb: got in=%h r=%h want 0", {sb_in1, sb_in2, sb_in3}, sb_r); end
        checks++; if ({out_s1, out_s2, out_s3} !== 192'd0) begin errors++;
            $display("FAIL reset_out: got %h want 0", {out_s1, out_s2, out_s3}); end
        rst = 1'b0;
    endtask

    task automatic test_plain();
        run_op(64'h0123456789ABCDEF, 64'd0, 64'd0, -1, -2, -1, -1,
               d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (d_rel != 23) begin errors++; $display("FAIL plain_done: got %0d want 23", d_rel); end
        checks++; if (xr !== 64'hB732FD89A6405EC1) begin errors++;
            $display("FAIL plain_result: got %h want b732fd89a6405ec1", xr); end
        checks++; if (e_o !== 1'b0 || b1 !== 1'b1) begin errors++;
            $display("FAIL plain_flags: got err=%b busy=%b want err=0 busy=1", e_o, b1); end
    endtask

    task automatic test_masked();
        a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
        a1 = 64'h0123456789ABCDEF ^ a2 ^ a3;
        run_op(a1, a2, a3, -1, -2, -1, 5, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (xr !== 64'hB732FD89A6405EC1 || d_rel != 23) begin errors++;
            $display("FAIL masked_result: got %h at %0d want b732fd89a6405ec1 at 23", xr, d_rel); end
        checks++; if (n_rdy != 22) begin errors++; $display("FAIL masked_ready_count: got %0d want 22", n_rdy); end
        checks++; if (bad != 0) begin errors++; $display("FAIL masked_sb_r: got %0d bad words want 0", bad); end
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 4; n++) begin
            x  = {$urandom, $urandom};
            a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
            run_op(x ^ a2 ^ a3, a2, a3, -1, -2, -1, 3 + n, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
            checks++; if (xr !== inv_layer(x) || d_rel != 23 || e_o !== 1'b0) begin errors++;
                $display("FAIL b2b_%0d: got %h at %0d err=%b want %h at 23 err=0", n, xr, d_rel, e_o, inv_layer(x)); end
        end
    endtask

    task automatic test_stall();
        x = {$urandom, $urandom};
        run_op(x, 64'd0, 64'd0, 1, 3, -1, -1, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (f_rdy != 4) begin errors++; $display("FAIL stall_first_issue: got %0d want 4", f_rdy); end
        checks++; if (d_rel != 26 || e_o !== 1'b0) begin errors++;
            $display("FAIL stall_done: got %0d err=%b want 26 err=0", d_rel, e_o); end
        checks++; if (xr !== inv_layer(x)) begin errors++; $display("FAIL stall_result: got %h want %h", xr, inv_layer(x)); end
    endtask

    task automatic test_starvation();
        x = {$urandom, $urandom};
        run_op(x, 64'd0, 64'd0, 8, 40, -1, -1, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (d_rel != 14) begin errors++; $display("FAIL starve_done: got %0d want 14", d_rel); end
        checks++; if (e_o !== 1'b1) begin errors++; $display("FAIL starve_err: got %b want 1", e_o); end
        checks++; if ({out_s1, out_s2, out_s3} !== 192'd0) begin errors++;
            $display("FAIL starve_out: got %h want 0", {out_s1, out_s2, out_s3}); end
        checks++; if (n_rdy != 7) begin errors++; $display("FAIL starve_ready_count: got %0d want 7", n_rdy); end
        @(negedge clk);
        rnd_valid = 1'b1;
        #1;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++;
            $display("FAIL starve_err_hold: got err=%b busy=%b want err=1 busy=0", err, busy); end
        x = {$urandom, $urandom};
        run_op(x, 64'd0, 64'd0, -1, -2, -1, -1, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (e1 !== 1'b0 || e_o !== 1'b0 || xr !== inv_layer(x)) begin errors++;
            $display("FAIL starve_recover: got err1=%b err=%b res=%h want 0 0 %h", e1, e_o, xr, inv_layer(x)); end
    endtask

    task automatic test_reset_mid();
        x = {$urandom, $urandom};
        run_op(x, 64'd0, 64'd0, -1, -2, 10, -1, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (d_rel != -1 || busy !== 1'b0) begin errors++;
            $display("FAIL rstmid_abandon: got done_at=%0d busy=%b want none busy=0", d_rel, busy); end
        x  = {$urandom, $urandom};
        a2 = {$urandom, $urandom}; a3 = {$urandom, $urandom};
        run_op(x ^ a2 ^ a3, a2, a3, -1, -2, -1, 4, d_rel, e_o, xr, n_rdy, f_rdy, bad, b1, e1);
        checks++; if (xr !== inv_layer(x) || d_rel != 23 || e_o !== 1'b0) begin errors++;
            $display("FAIL rstmid_new: got %h at %0d err=%b want %h at 23 err=0", xr, d_rel, e_o, inv_layer(x)); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd = '0;
        in_s1 = '0; in_s2 = '0; in_s3 = '0;
        test_reset();
        test_plain();
        test_masked();
        test_back_to_back();
        test_stall();
        test_starvation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
